// File: rtl/router_pkg.sv
// Shared types and constants for the router read-side blocks.
// Header layout: {payload_len[5:0], addr[1:0]}.
package router_pkg;

  localparam int DATA_W      = 8;
  localparam int HDR_LEN_MSB = 7;
  localparam int HDR_LEN_LSB = 2;
  localparam int HDR_ADDR_W  = 2;
  localparam int LEN_W       = HDR_LEN_MSB - HDR_LEN_LSB + 1;
  localparam int DEF_TIMEOUT = 30;

  typedef enum logic [1:0] {
    S_HDR = 2'd0,
    S_PAY = 2'd1,
    S_PAR = 2'd2
  } state_e;

endpackage

// File: rtl/router_idle_timer.sv
// Idle-cycle counter with clear/enable; expire_o fires on the
// enabled cycle that would bring the count up to LIMIT.
module router_idle_timer #(
  parameter int LIMIT = 30
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] cnt_q, cnt_d;

  assign expire_o = en_i & ~clr_i & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || expire_o)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/router_out_reader.sv
// Drains one router output FIFO: parses header/payload/parity,
// forwards payload, flags errors and aborts stalled packets.
module router_out_reader
  import router_pkg::*;
#(
  parameter logic [HDR_ADDR_W-1:0] PORT_ID = '0,
  parameter int                    TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_empty,
  output logic              fifo_read_en,
  output logic              fifo_soft_reset,
  input  logic              sink_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic              pkt_done,
  output logic [LEN_W-1:0]  pkt_len,
  output logic              pkt_par_err,
  output logic              pkt_addr_err,
  output logic              pkt_abort,
  output logic              busy
);

  state_e                  state_q, state_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [HDR_ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]       par_q, par_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;
  logic                    rd_vld_q;
  logic [DATA_W-1:0]       data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic                    done_q, done_d;
  logic                    perr_q, perr_d;
  logic                    aerr_q, aerr_d;
  logic                    inflight;
  logic                    abort;

  assign inflight = (state_q != S_HDR);

  // A popped byte clears the timer, so it always beats expiry.
  router_idle_timer #(
    .LIMIT(TIMEOUT)
  ) u_idle (
    .clock   (clock),
    .reset_n (reset_n),
    .clr_i   (rd_vld_q | ~inflight),
    .en_i    (inflight & ~rd_vld_q),
    .expire_o(abort)
  );

  assign fifo_read_en    = ~fifo_empty & sink_ready & ~abort;
  assign fifo_soft_reset = abort;
  assign pkt_abort       = abort;
  assign busy            = inflight;
  assign out_data        = data_q;
  assign out_valid       = valid_q;
  assign out_last        = last_q;
  assign pkt_done        = done_q;
  assign pkt_len         = len_q;
  assign pkt_par_err     = perr_q;
  assign pkt_addr_err    = aerr_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    par_d   = par_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = 1'b0;
    last_d  = 1'b0;
    done_d  = 1'b0;
    perr_d  = 1'b0;
    aerr_d  = 1'b0;
    if (abort) begin
      state_d = S_HDR;
      par_d   = '0;
      cnt_d   = '0;
    end else if (rd_vld_q) begin
      unique case (state_q)
        S_HDR: begin
          len_d   = fifo_data[HDR_LEN_MSB:HDR_LEN_LSB];
          addr_d  = fifo_data[HDR_ADDR_W-1:0];
          par_d   = fifo_data;
          cnt_d   = '0;
          state_d = (len_d != '0) ? S_PAY : S_PAR;
        end
        S_PAY: begin
          data_d  = fifo_data;
          valid_d = 1'b1;
          last_d  = (cnt_q == len_q - 6'd1);
          par_d   = par_q ^ fifo_data;
          cnt_d   = cnt_q + 6'd1;
          if (cnt_d == len_q)
            state_d = S_PAR;
        end
        S_PAR: begin
          done_d  = 1'b1;
          perr_d  = (par_q != fifo_data);
          aerr_d  = (addr_q != PORT_ID);
          par_d   = '0;
          state_d = S_HDR;
        end
        default: state_d = S_HDR;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= S_HDR;
      len_q    <= '0;
      addr_q   <= '0;
      par_q    <= '0;
      cnt_q    <= '0;
      rd_vld_q <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      perr_q   <= 1'b0;
      aerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
      par_q    <= par_d;
      cnt_q    <= cnt_d;
      rd_vld_q <= fifo_read_en & ~fifo_empty;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      done_q   <= done_d;
      perr_q   <= perr_d;
      aerr_q   <= aerr_d;
    end
  end

endmodule

// File: tb/tb_router_out_reader.sv
// Directed bench for router_out_reader with a 1-cycle-latency
// FIFO model and an output monitor.
module tb_router_out_reader;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] fifo_data = '0;
  logic       fifo_empty;
  logic       fifo_read_en;
  logic       fifo_soft_reset;
  logic       sink_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       pkt_done;
  logic [5:0] pkt_len;
  logic       pkt_par_err;
  logic       pkt_addr_err;
  logic       pkt_abort;
  logic       busy;

  int checks = 0;
  int failures = 0;

  router_out_reader #(
    .PORT_ID(2'd2),
    .TIMEOUT(30)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .fifo_data      (fifo_data),
    .fifo_empty     (fifo_empty),
    .fifo_read_en   (fifo_read_en),
    .fifo_soft_reset(fifo_soft_reset),
    .sink_ready     (sink_ready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_last       (out_last),
    .pkt_done       (pkt_done),
    .pkt_len        (pkt_len),
    .pkt_par_err    (pkt_par_err),
    .pkt_addr_err   (pkt_addr_err),
    .pkt_abort      (pkt_abort),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clock) begin
    if (fifo_soft_reset)
      rd_ptr <= wr_ptr;
    else if (fifo_read_en) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  int         cyc = 0;
  logic [7:0] cap [0:255];
  logic       capl [0:255];
  int         ncap = 0;
  int         ov_cyc = 0;
  int         done_cnt = 0;
  int         done_cyc [0:7];
  int         ncap_at_done [0:7];
  logic       last_perr = 1'b0;
  logic       last_aerr = 1'b0;
  int         abort_cnt = 0;
  int         abort_cyc = 0;
  int         sr_cnt = 0;

  always @(negedge clock) begin
    cyc++;
    if (out_valid) begin
      cap[ncap]  = out_data;
      capl[ncap] = out_last;
      ov_cyc     = cyc;
      ncap++;
    end
    if (pkt_done) begin
      if (done_cnt < 8) begin
        done_cyc[done_cnt]     = cyc;
        ncap_at_done[done_cnt] = ncap;
      end
      done_cnt++;
      last_perr = pkt_par_err;
      last_aerr = pkt_addr_err;
    end
    if (pkt_abort) begin
      abort_cnt++;
      abort_cyc = cyc;
    end
    if (fifo_soft_reset)
      sr_cnt++;
  end

  logic [7:0] exp_b [0:255];
  int         nexp = 0;

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr++;
  endtask

  task automatic clear_mon();
    ncap = 0;
    nexp = 0;
    done_cnt = 0;
    abort_cnt = 0;
    sr_cnt = 0;
    last_perr = 1'b0;
    last_aerr = 1'b0;
  endtask

  // Pushes header, n random payload bytes, and parity ^ flip.
  task automatic push_pkt(input logic [7:0] hdr, input logic [7:0] flip);
    logic [7:0] p;
    logic [7:0] b;
    p = hdr;
    push(hdr);
    for (int i = 0; i < int'(hdr[7:2]); i++) begin
      b = 8'($urandom_range(0, 255));
      exp_b[nexp] = b;
      nexp++;
      p = p ^ b;
      push(b);
    end
    push(p ^ flip);
  endtask

  task automatic wait_done(input int n);
    int k;
    k = 0;
    while (done_cnt < n && k < 400) begin
      step();
      k++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    checks++;
    if ({out_valid, out_last, pkt_done, pkt_par_err, pkt_addr_err,
         pkt_abort, fifo_soft_reset} !== 7'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=0",
               {out_valid, out_last, pkt_done, pkt_par_err, pkt_addr_err,
                pkt_abort, fifo_soft_reset});
    end
    checks++;
    if (busy !== 1'b0 || pkt_len !== 6'd0 || out_data !== 8'd0) begin
      failures++;
      $display("FAIL reset_state busy=%b len=%0d data=%h want 0",
               busy, pkt_len, out_data);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    clear_mon();
    push_pkt(8'h3A, 8'h00);
    wait_done(1);
    step();
    checks++;
    if (ncap !== 14) begin
      failures++;
      $display("FAIL single_count got=%0d want=14", ncap);
    end
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (cap[i] !== exp_b[i] || capl[i] !== (i == 13)) begin
        failures++;
        $display("FAIL single_byte%0d got=%h/%b want=%h/%b",
                 i, cap[i], capl[i], exp_b[i], (i == 13));
      end
    end
    checks++;
    if (done_cnt !== 1 || last_perr !== 1'b0 || last_aerr !== 1'b0) begin
      failures++;
      $display("FAIL single_done done=%0d perr=%b aerr=%b want 1/0/0",
               done_cnt, last_perr, last_aerr);
    end
    checks++;
    if (pkt_len !== 6'd14) begin
      failures++;
      $display("FAIL single_len got=%0d want=14", pkt_len);
    end
  endtask

  task automatic test_par_err();
    clear_mon();
    push_pkt(8'h3A, 8'h01);
    wait_done(1);
    step();
    checks++;
    if (done_cnt !== 1 || last_perr !== 1'b1) begin
      failures++;
      $display("FAIL parerr_flag done=%0d perr=%b want 1/1",
               done_cnt, last_perr);
    end
    clear_mon();
    push_pkt(8'h0E, 8'h00);
    wait_done(1);
    step();
    checks++;
    if (done_cnt !== 1 || last_perr !== 1'b0 || ncap !== 3 ||
        cap[0] !== exp_b[0] || cap[2] !== exp_b[2]) begin
      failures++;
      $display("FAIL parerr_next done=%0d perr=%b n=%0d want 1/0/3",
               done_cnt, last_perr, ncap);
    end
  endtask

  task automatic test_zero_b2b();
    clear_mon();
    push_pkt(8'h02, 8'h00);
    push_pkt(8'h0E, 8'h00);
    wait_done(2);
    step();
    checks++;
    if (done_cnt !== 2 || ncap_at_done[0] !== 0) begin
      failures++;
      $display("FAIL zero_first done=%0d ncap_at_done=%0d want 2/0",
               done_cnt, ncap_at_done[0]);
    end
    checks++;
    if (ncap !== 3 || cap[0] !== exp_b[0] || cap[1] !== exp_b[1] ||
        cap[2] !== exp_b[2] || capl[2] !== 1'b1 || last_perr !== 1'b0) begin
      failures++;
      $display("FAIL b2b_data n=%0d last=%b perr=%b want 3/1/0",
               ncap, capl[2], last_perr);
    end
    checks++;
    if (done_cyc[1] - done_cyc[0] !== 5) begin
      failures++;
      $display("FAIL b2b_gap got=%0d want=5", done_cyc[1] - done_cyc[0]);
    end
  endtask

  task automatic test_addr();
    clear_mon();
    push_pkt(8'h11, 8'h00);
    wait_done(1);
    step();
    checks++;
    if (ncap !== 4 || cap[3] !== exp_b[3] || capl[3] !== 1'b1) begin
      failures++;
      $display("FAIL addr_payload n=%0d got=%h want=4/%h", ncap, cap[3], exp_b[3]);
    end
    checks++;
    if (last_aerr !== 1'b1 || last_perr !== 1'b0) begin
      failures++;
      $display("FAIL addr_err aerr=%b perr=%b want 1/0", last_aerr, last_perr);
    end
  endtask

  task automatic test_timeout();
    int k;
    clear_mon();
    push(8'h16);
    push(8'h21);
    push(8'h43);
    k = 0;
    while (ncap < 2 && k < 100) begin step(); k++; end
    k = 0;
    while (abort_cnt < 1 && k < 60) begin step(); k++; end
    checks++;
    if (abort_cnt !== 1 || abort_cyc - ov_cyc !== 29) begin
      failures++;
      $display("FAIL timeout_when aborts=%0d delta=%0d want 1/29",
               abort_cnt, abort_cyc - ov_cyc);
    end
    repeat (5) step();
    checks++;
    if (abort_cnt !== 1 || sr_cnt !== 1 || done_cnt !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_pulse ab=%0d sr=%0d done=%0d busy=%b want 1/1/0/0",
               abort_cnt, sr_cnt, done_cnt, busy);
    end
    clear_mon();
    push_pkt(8'h0A, 8'h00);
    wait_done(1);
    step();
    checks++;
    if (done_cnt !== 1 || last_perr !== 1'b0 || ncap !== 2 ||
        cap[1] !== exp_b[1] || pkt_len !== 6'd2) begin
      failures++;
      $display("FAIL timeout_next done=%0d perr=%b n=%0d len=%0d want 1/0/2/2",
               done_cnt, last_perr, ncap, pkt_len);
    end
  endtask

  task automatic test_timeout_edge();
    int k;
    clear_mon();
    push(8'h16);
    push(8'h01);
    push(8'h02);
    k = 0;
    while (ncap < 2 && k < 100) begin step(); k++; end
    repeat (28) step();
    push(8'h04);
    push(8'h08);
    push(8'h10);
    push(8'h16 ^ 8'h1F);
    wait_done(1);
    step();
    checks++;
    if (abort_cnt !== 0 || done_cnt !== 1 || last_perr !== 1'b0 || ncap !== 5) begin
      failures++;
      $display("FAIL timeout_edge ab=%0d done=%0d perr=%b n=%0d want 0/1/0/5",
               abort_cnt, done_cnt, last_perr, ncap);
    end
  endtask

  task automatic test_backpressure();
    int k;
    clear_mon();
    push_pkt(8'h2A, 8'h00);
    k = 0;
    while (done_cnt < 1 && k < 200) begin
      sink_ready = ~sink_ready;
      step();
      k++;
    end
    sink_ready = 1'b1;
    step();
    checks++;
    if (ncap !== 10 || done_cnt !== 1 || last_perr !== 1'b0) begin
      failures++;
      $display("FAIL bp_done n=%0d done=%0d perr=%b want 10/1/0",
               ncap, done_cnt, last_perr);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (cap[i] !== exp_b[i]) begin
        failures++;
        $display("FAIL bp_byte%0d got=%h want=%h", i, cap[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int k;
    clear_mon();
    push(8'h22);
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    k = 0;
    while (ncap < 4 && k < 100) begin step(); k++; end
    reset_n = 1'b0;
    step();
    step();
    checks++;
    if ({out_valid, pkt_done, busy, pkt_abort} !== 4'b0 ||
        pkt_len !== 6'd0 || out_data !== 8'd0) begin
      failures++;
      $display("FAIL midreset_state v=%b d=%b busy=%b len=%0d data=%h want 0",
               out_valid, pkt_done, busy, pkt_len, out_data);
    end
    reset_n = 1'b1;
    clear_mon();
    push(8'h06);
    push(8'hA5);
    push(8'hA3);
    wait_done(1);
    step();
    checks++;
    if (done_cnt !== 1 || last_perr !== 1'b0 || ncap !== 1 ||
        cap[0] !== 8'hA5 || pkt_len !== 6'd1 || abort_cnt !== 0) begin
      failures++;
      $display("FAIL midreset_next done=%0d perr=%b n=%0d d=%h len=%0d want 1/0/1/a5/1",
               done_cnt, last_perr, ncap, cap[0], pkt_len);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_par_err();
    test_zero_b2b();
    test_addr();
    test_timeout();
    test_timeout_edge();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/router_out_reader.md
Name: router_out_reader

Overview:
- Drains one router output FIFO and consumes the byte stream its writer produces: header {payload_len[5:0], addr[1:0]}, then payload_len payload bytes, then one parity byte.
- Parses each packet, forwards payload bytes to the destination sink, and checks parity and address.
- Mid-packet stalls are detected; on a stall the block aborts the packet and pulses a FIFO soft reset.
- One instance sits at the output of each FIFO, on the read side of the router.

Parameters:
- PORT_ID, 2'd0: expected header addr[1:0] for this port.
- TIMEOUT, 30: idle cycles tolerated mid-packet before abort; legal range 1..255.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  reset; synchronous, active-low.
- fifo_data  in  8  FIFO read data; valid the cycle after a successful pop.
- fifo_empty  in  1  FIFO empty flag.
- fifo_read_en  out  1  FIFO pop request.
- fifo_soft_reset  out  1  one-cycle FIFO flush pulse.
- sink_ready  in  1  destination can accept a byte next cycle.
- out_data  out  8  payload byte.
- out_valid  out  1  out_data valid this cycle.
- out_last  out  1  with out_valid, marks the final payload byte.
- pkt_done  out  1  one-cycle pulse when the parity byte is consumed.
- pkt_len  out  6  payload_len of the current/last packet; stable from the header onward.
- pkt_par_err  out  1  valid with pkt_done: computed parity ≠ received parity.
- pkt_addr_err  out  1  valid with pkt_done: header addr ≠ PORT_ID.
- pkt_abort  out  1  one-cycle pulse on timeout abort.
- busy  out  1  high while state ≠ S_HDR.

Behaviour:
- Reset (reset_n=0 at a clock edge) clears all outputs to 0 and sets state S_HDR, counters 0, parity accumulator 0. This overrides any in-flight pop; a byte returning the next cycle is discarded.
- Read issue: fifo_read_en = ~fifo_empty & sink_ready & ~abort_cycle (combinational).
- Pop tracking: registered rd_vld = fifo_read_en & ~fifo_empty. When rd_vld=1, fifo_data holds a stream byte; read latency is 1 cycle.
- Byte processing happens only on cycles with rd_vld=1.
  - S_HDR:
    - Latch len = byte[7:2] and addr = byte[1:0].
    - Set par = byte.
    - Set cnt = 0.
    - Next state is S_PAY if len≠0, else S_PAR.
  - S_PAY:
    - Outputs are registered: out_data = byte, out_valid = 1 on the following cycle.
    - out_last = 1 when cnt == len-1.
    - par ^= byte; cnt++.
    - When cnt reaches len, next state is S_PAR.
  - S_PAR:
    - pkt_done = 1.
    - pkt_par_err = (par ≠ byte).
    - pkt_addr_err = (addr ≠ PORT_ID).
    - Next state is S_HDR.
    - All three outputs are registered, one cycle after rd_vld.
- Back-to-back packets: no dead cycle required. A header may follow a parity byte on consecutive rd_vld cycles.
- Idle counter:
  - Counts in S_PAY and S_PAR on cycles with rd_vld=0.
  - Clears on rd_vld=1 and in S_HDR.
  - A byte arriving in the same cycle the counter would reach TIMEOUT wins; the counter clears and there is no abort.
- Abort: when the idle counter == TIMEOUT:
  - Pulse pkt_abort and fifo_soft_reset for 1 cycle; abort_cycle suppresses fifo_read_en in that cycle.
  - State goes to S_HDR, par clears, and pkt_done does not fire.
- Backpressure: sink_ready=0 stalls pops only. Stall cycles count toward the idle counter.
- pkt_len keeps its value until the next header.
- Widths: par is 8-bit XOR; cnt is 6-bit, and len=63 must not wrap before completion.

Decomposition:
- Shared package router_pkg:
  - state enum {S_HDR, S_PAY, S_PAR}
  - HDR_LEN_MSB=7, HDR_LEN_LSB=2, HDR_ADDR_W=2
  - DATA_W=8
  - default TIMEOUT
- Sub-module router_idle_timer (counter, clear, enable, expire pulse) is natural and reusable by the router sync block.
- The FSM and datapath stay in router_out_reader.

Test Plan:
- Reset then single packet, PORT_ID=2: header 8'h3A (len 14, addr 2), 14 random bytes, correct parity byte, sink_ready=1 → 14 out_valid pulses with matching data, out_last on the 14th, pkt_done=1, pkt_par_err=0, pkt_addr_err=0, pkt_len=14.
- Parity error: same packet with parity byte XOR 8'h01 → pkt_done=1 and pkt_par_err=1; next packet is parsed normally.
- Zero-length packet plus back-to-back: header 8'h02, parity 8'h02, immediately followed by a len-3 packet → pkt_done for the first packet with no out_valid, then 3 out_valid and a second pkt_done; no dead cycle between packets.
- Address mismatch: header addr 1, PORT_ID=2 → full payload delivered; at pkt_done, pkt_addr_err=1.
- Timeout: header len 5, 2 payload bytes, then FIFO held empty → pkt_abort and fifo_soft_reset pulse once on the 30th idle cycle; no pkt_done; next header parsed correctly. Variant: a byte arrives on idle cycle 30 → no abort.
- Reset mid-packet and backpressure:
  - sink_ready toggled 1/0 every cycle during a len-10 packet → all bytes delivered in order and parity OK.
  - reset_n=0 after byte 4 → all outputs 0, state S_HDR, and the next packet is parsed cleanly.
